// File: rtl/interval_capture_pkg.sv
// rtl/interval_capture_pkg.sv - shared FSM state type and counter width helper for interval_capture
package interval_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Width needed to hold the saturated value MAX_COUNT itself, not just MAX_COUNT-1.
    function automatic int calc_cnt_w(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// rtl/edge_rise_det.sv - rising-edge pulse detector, optional 2-flop synchronizer (INTERVAL_CAPTURE_SYNC_EN)
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic rise
);

    logic x_q;
    logic x_s;

`ifdef INTERVAL_CAPTURE_SYNC_EN
    logic sync_1, sync_2;

    // Synchronizer resets high so a line already high at reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= x;
            sync_2 <= sync_1;
        end
    end

    assign x_s = sync_2;
`else
    assign x_s = x;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= 1'b1;
        end else begin
            x_q <= x_s;
        end
    end

    assign rise = x_s & ~x_q;

endmodule

// File: rtl/interval_capture.sv
// rtl/interval_capture.sv - measures clk cycles between start_evt and stop_evt rising edges
// Optional input synchronizers enabled with INTERVAL_CAPTURE_SYNC_EN.
module interval_capture
    import interval_capture_pkg::*;
#(
    parameter int  MAX_COUNT = 100_000_000,
    localparam int CNT_W     = calc_cnt_w(MAX_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             start_evt,
    input  logic             stop_evt,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_ovf,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             rise_start;
    logic             rise_stop;

    edge_rise_det u_start_det (
        .clk  (clk),
        .rst  (rst),
        .x    (start_evt),
        .rise (rise_start)
    );

    edge_rise_det u_stop_det (
        .clk  (clk),
        .rst  (rst),
        .x    (stop_evt),
        .rise (rise_stop)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            meas_valid <= 1'b0;
            meas_count <= '0;
            meas_ovf   <= 1'b0;
        end else if (abort) begin
            // Abort wins over events and the handshake; the last result stays readable.
            state      <= IDLE;
            counter    <= '0;
            meas_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (rise_start) begin
                        state   <= RUN;
                        counter <= '0;
                    end
                end
                RUN: begin
                    if (rise_stop) begin
                        meas_count <= counter + CNT_W'(1);
                        meas_ovf   <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (counter == CNT_W'(MAX_COUNT - 1)) begin
                        meas_count <= CNT_W'(MAX_COUNT);
                        meas_ovf   <= 1'b1;
                        meas_valid <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (meas_valid && meas_ready) begin
                        meas_valid <= 1'b0;
                        state      <= arm ? ARMED : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_capture.sv
// tb/tb_interval_capture.sv - randomized and directed bench for interval_capture against a timestamp model
module tb_interval_capture;

    localparam int MAXC = 16;
    localparam int CW   = 5;
`ifdef INTERVAL_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_HOLD  = 3;

    logic          clk = 1'b0;
    logic          rst, arm, abort, start_evt, stop_evt, meas_ready;
    logic          meas_valid, meas_ovf, busy;
    logic [CW-1:0] meas_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model: measurement as difference of event timestamps.
    int   cyc = 0;
    int   m_mode, m_t0, m_count;
    bit   m_valid, m_ovf;
    bit   hist_start[2], hist_stop[2];
    bit   prev_start, prev_stop;

    interval_capture #(.MAX_COUNT(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .start_evt  (start_evt),
        .stop_evt   (stop_evt),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_count (meas_count),
        .meas_ovf   (meas_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit eff_start, eff_stop, rs, rp;
        int elapsed;
        cyc++;
        if (rst) begin
            m_mode = M_IDLE; m_valid = 0; m_count = 0; m_ovf = 0;
            prev_start = 1; prev_stop = 1;
            hist_start = '{1, 1}; hist_stop = '{1, 1};
            return;
        end
        eff_start = (LAT == 0) ? start_evt : hist_start[LAT-1];
        eff_stop  = (LAT == 0) ? stop_evt  : hist_stop[LAT-1];
        rs = eff_start && !prev_start;
        rp = eff_stop && !prev_stop;
        prev_start = eff_start;
        prev_stop  = eff_stop;
        hist_start[1] = hist_start[0]; hist_start[0] = start_evt;
        hist_stop[1]  = hist_stop[0];  hist_stop[0]  = stop_evt;
        if (abort) begin
            m_mode  = M_IDLE;
            m_valid = 0;
            return;
        end
        case (m_mode)
            M_IDLE:  if (arm) m_mode = M_ARMED;
            M_ARMED: if (rs) begin m_mode = M_RUN; m_t0 = cyc; end
            M_RUN: begin
                elapsed = cyc - m_t0;
                if (rp || elapsed >= MAXC) begin
                    m_count = (elapsed > MAXC) ? MAXC : elapsed;
                    m_ovf   = !rp;
                    m_valid = 1;
                    m_mode  = M_HOLD;
                end
            end
            default: if (meas_ready) begin
                m_valid = 0;
                m_mode  = arm ? M_ARMED : M_IDLE;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", busy, (m_mode != M_IDLE));
        check("meas_valid", meas_valid, m_valid);
        check("meas_count", meas_count, m_count);
        check("meas_ovf", meas_ovf, m_ovf);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!meas_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid_timeout", meas_valid, 1'b1);
    endtask

    task automatic pulse_start();
        start_evt = 1; tick(); start_evt = 0;
    endtask

    task automatic pulse_stop();
        stop_evt = 1; tick(); stop_evt = 0;
    endtask

    task automatic arm_pulse();
        arm = 1; tick(); arm = 0;
    endtask

    initial begin
        rst = 1; arm = 0; abort = 0; start_evt = 0; stop_evt = 0; meas_ready = 0;
        @(negedge clk);
        ticks(3);
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_count", meas_count, 0);
        check("rst_ovf", meas_ovf, 0);
        ticks(2);

        // Basic 7-cycle measurement, consumer always ready.
        meas_ready = 1;
        arm_pulse();
        ticks(8);
        pulse_start();
        ticks(6);
        pulse_stop();
        wait_valid(10);
        check("basic_count", meas_count, 7);
        check("basic_ovf", meas_ovf, 0);
        tick();
        check("basic_idle", busy, 0);

        // Overflow: no stop, stop during HOLD ignored.
        meas_ready = 0;
        arm_pulse();
        pulse_start();
        wait_valid(MAXC + 8);
        check("ovf_count", meas_count, MAXC);
        check("ovf_flag", meas_ovf, 1);
        pulse_stop();
        ticks(2);
        check("ovf_hold_count", meas_count, MAXC);
        meas_ready = 1; tick(); meas_ready = 0;
        check("ovf_released", meas_valid, 0);

        // Simultaneous start+stop in ARMED, stop again 3 later; stop-only in ARMED ignored.
        arm_pulse();
        pulse_stop();
        ticks(4);
        check("stop_only_armed", busy, 1);
        check("stop_only_novalid", meas_valid, 0);
        start_evt = 1; stop_evt = 1; tick(); start_evt = 0; stop_evt = 0;
        ticks(2);
        pulse_stop();
        wait_valid(10);
        check("same_cycle_count", meas_count, 3);

        // Long hold with ready low, then handshake with arm held.
        ticks(20);
        check("hold_valid", meas_valid, 1);
        check("hold_count", meas_count, 3);
        meas_ready = 1; arm = 1; tick(); meas_ready = 0; arm = 0;
        check("rearm_valid", meas_valid, 0);
        check("rearm_busy", busy, 1);

        // Abort mid-run, then a clean 4-cycle measurement.
        pulse_start();
        ticks(5);
        abort = 1; tick(); abort = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", meas_valid, 0);
        ticks(3);
        meas_ready = 1;
        arm_pulse();
        pulse_start();
        ticks(3);
        pulse_stop();
        wait_valid(10);
        check("post_abort_count", meas_count, 4);
        tick();

        // start_evt held high across reset is not an edge.
        rst = 1; start_evt = 1; ticks(2); rst = 0;
        arm_pulse();
        ticks(5);
        check("held_start_armed", busy, 1);
        check("held_start_novalid", meas_valid, 0);
        start_evt = 0; ticks(1);
        pulse_start();
        ticks(3);
        rst = 1; tick(); rst = 0;
        check("rst_run_busy", busy, 0);
        check("rst_run_count", meas_count, 0);
        ticks(2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            arm        = ($urandom_range(0, 3) == 0);
            meas_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) start_evt = ~start_evt;
            if ($urandom_range(0, 5) == 0) stop_evt = ~stop_evt;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
